// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller:
// FSM states, access size codes, lane masks and request classification helpers.
package mem_access_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE_RD,
        ST_CAPTURE,
        ST_ISSUE_WR,
        ST_RESP
    } state_t;

    typedef enum logic [1:0] {
        SIZE_WORD     = 2'b00,
        SIZE_HALF     = 2'b01,
        SIZE_BYTE     = 2'b10,
        SIZE_WORD_ALT = 2'b11
    } size_t;

    localparam logic [31:0] LANE_MASK_BYTE = 32'h0000_00FF;
    localparam logic [31:0] LANE_MASK_HALF = 32'h0000_FFFF;

    function automatic logic is_word(input size_t size);
        return (size == SIZE_WORD) || (size == SIZE_WORD_ALT);
    endfunction

    function automatic logic is_misaligned(input size_t size, input logic [1:0] off);
        case (size)
            SIZE_HALF: return off[0];
            SIZE_BYTE: return 1'b0;
            default:   return off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Pipeline request/response and synchronous data-memory signals of mem_access_ctrl.
// slave = controller view, master = pipeline plus memory view.
interface mem_access_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic        mem_en;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_access_ctrl_lane_align.sv
// Combinational lane logic: extracts a sized, extended load value from a memory word
// and merges a sub-word store lane into the previous word contents.
module lane_align
    import mem_access_ctrl_pkg::*;
(
    input  size_t       size,
    input  logic        is_signed,
    input  logic [1:0]  off,
    input  logic [31:0] rd_word,
    output logic [31:0] load_data,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] merged
);

    logic [4:0]  sh;
    logic [31:0] lane_mask;
    logic [31:0] lane;

    always_comb begin
        sh        = '0;
        lane_mask = '1;
        case (size)
            SIZE_HALF: begin
                sh        = {off[1], 4'b0000};
                lane_mask = LANE_MASK_HALF;
            end
            SIZE_BYTE: begin
                sh        = {off, 3'b000};
                lane_mask = LANE_MASK_BYTE;
            end
            default: ;
        endcase

        lane      = (rd_word >> sh) & lane_mask;
        load_data = lane;
        if (is_signed) begin
            if (size == SIZE_HALF && lane[15]) load_data = lane | ~LANE_MASK_HALF;
            if (size == SIZE_BYTE && lane[7])  load_data = lane | ~LANE_MASK_BYTE;
        end

        // Word accesses use an all-ones mask at shift 0, so the merge yields wdata.
        merged = (old_word & ~(lane_mask << sh)) | ((wdata & lane_mask) << sh);
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Data-memory access controller: single-request FSM with registered outputs,
// read-modify-write for sub-word stores, misalignment detection.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    mem_access_ctrl_if.slave bus
);

    state_t      state_q, state_d;
    logic        we_q, we_d;
    size_t       size_q, size_d;
    logic        signed_q, signed_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic        mem_en_q, mem_en_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic [31:0] load_data;
    logic [31:0] merged_word;
    size_t       in_size;

    lane_align u_lane_align (
        .size      (size_q),
        .is_signed (signed_q),
        .off       (addr_q[1:0]),
        .rd_word   (bus.mem_rdata),
        .load_data (load_data),
        .old_word  (bus.mem_rdata),
        .wdata     (wdata_q),
        .merged    (merged_word)
    );

    assign in_size = size_t'(bus.req_size);

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        size_d       = size_q;
        signed_d     = signed_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        req_ready_d  = 1'b0;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            ST_IDLE: begin
                req_ready_d = 1'b1;
                if (bus.req_valid && req_ready_q) begin
                    we_d        = bus.req_we;
                    size_d      = in_size;
                    signed_d    = bus.req_signed;
                    addr_d      = bus.req_addr;
                    wdata_d     = bus.req_wdata;
                    req_ready_d = 1'b0;
                    if (is_misaligned(in_size, bus.req_addr[1:0])) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (bus.req_we && is_word(in_size)) begin
                        state_d     = ST_ISSUE_WR;
                        mem_en_d    = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_wdata_d = bus.req_wdata;
                    end else begin
                        // Loads and sub-word stores both need the current word first.
                        state_d  = ST_ISSUE_RD;
                        mem_en_d = 1'b1;
                    end
                end
            end
            ST_ISSUE_RD: state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                if (!we_q) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_data;
                end else begin
                    state_d     = ST_ISSUE_WR;
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = merged_word;
                end
            end
            ST_ISSUE_WR: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
            end
            ST_RESP: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            size_q       <= SIZE_WORD;
            signed_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.mem_en     = mem_en_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = addr_q[31:2];
    assign bus.mem_wdata  = mem_wdata_q;

endmodule
